// File: rtl/grng_sample_collector.sv
// grng_sample_collector: accept/reject stage, Q7.28 -> Q3.14 saturating
// conversion and drop-on-overflow output FIFO for the Gaussian RNG pipeline.
// Optional statistics counters: define GRNG_COLLECTOR_STATS_EN.
module grng_sample_collector #(
  parameter int unsigned LOG2N = 8,
  parameter int unsigned LOG2D = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [LOG2N-1:0]   rect_idx_in,
  input  logic [35:0]        mult_value,
  input  logic               cmp_value,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [17:0]        out_sample,
  output logic [LOG2D:0]     level,
  output logic               overflow,
  output logic [31:0]        accept_cnt,
  output logic [31:0]        reject_cnt,
  output logic [15:0]        drop_cnt
);

  localparam int unsigned DEPTH = 1 << LOG2D;
  localparam int unsigned LW    = LOG2D + 1;

  logic              accept_c;
  logic [17:0]       conv_c;
  logic              a_valid;
  logic [17:0]       a_sample;
  logic [17:0]       mem [DEPTH];
  logic [LOG2D-1:0]  wr_ptr;
  logic [LOG2D-1:0]  rd_ptr;
  logic              full_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;
  logic              unused_lsbs_c;

  // Fraction bits below Q3.14 resolution are truncated away.
  assign unused_lsbs_c = ^mult_value[13:0];

  // Accept decision; tail bundles (index 0) are handled by another path.
  assign accept_c = valid_in & cmp_value & (rect_idx_in != '0);

  // Q7.28 -> Q3.14: pass through when the top five bits agree, else clamp.
  always_comb begin
    conv_c = mult_value[31:14];
    if (!((&mult_value[35:31]) | ~(|mult_value[35:31]))) begin
      conv_c = mult_value[35] ? 18'h20000 : 18'h1FFFF;
    end
  end

  // A full FIFO still takes a push when the head leaves on the same edge.
  assign full_c = (level == LW'(DEPTH));
  assign pop_c  = out_valid & out_ready & ~flush;
  assign push_c = a_valid & ~flush & (~full_c | pop_c);
  assign drop_c = a_valid & ~flush & full_c & ~pop_c;

  // Stage A: register the accept decision and converted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_sample <= '0;
    end else if (flush) begin
      a_valid  <= 1'b0;
    end else begin
      a_valid  <= accept_c;
      a_sample <= conv_c;
    end
  end

  // FIFO storage write; contents are qualified by level so need no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= a_sample;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + LOG2D'(1);
      if (pop_c)  rd_ptr <= rd_ptr + LOG2D'(1);
      if (push_c && !pop_c)      level <= level + LW'(1);
      else if (pop_c && !push_c) level <= level - LW'(1);
    end
  end

  // Sticky overflow flag, survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         overflow <= 1'b0;
    else if (drop_c) overflow <= 1'b1;
  end

  assign out_valid  = (level != '0);
  assign out_sample = out_valid ? mem[rd_ptr] : '0;

`ifdef GRNG_COLLECTOR_STATS_EN
  // Saturating statistics counters; a flushed bundle is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accept_cnt <= '0;
      reject_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (accept_c && !flush && accept_cnt != '1)
        accept_cnt <= accept_cnt + 32'd1;
      if (valid_in && !accept_c && !flush && reject_cnt != '1)
        reject_cnt <= reject_cnt + 32'd1;
      if (drop_c && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign accept_cnt = '0;
  assign reject_cnt = '0;
  assign drop_cnt   = '0;
`endif

endmodule

// File: tb/tb_grng_sample_collector.sv
// Bench for grng_sample_collector: conversion vector table, a reference
// queue of expected samples checked every cycle, and hand-written sequences
// for latency, overflow, full push/pop, flush and asynchronous reset.
module tb_grng_sample_collector;

`ifdef GRNG_COLLECTOR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [7:0]  rect_idx_in;
  logic [35:0] mult_value;
  logic        cmp_value;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sample;
  logic [4:0]  level;
  logic        overflow;
  logic [31:0] accept_cnt;
  logic [31:0] reject_cnt;
  logic [15:0] drop_cnt;

  grng_sample_collector #(.LOG2N(8), .LOG2D(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .rect_idx_in(rect_idx_in),
    .mult_value(mult_value), .cmp_value(cmp_value), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .level(level), .overflow(overflow), .accept_cnt(accept_cnt),
    .reject_cnt(reject_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Expected sample for the bundle currently driven (hand-derived).
  logic [17:0] exp_in;

  // Reference: one-cycle stage, 16-deep queue, drop when full without pop.
  logic [17:0] m_q[$];
  bit          m_sv;
  logic [17:0] m_ss;
  bit          m_ovf;
  bit          m_pop;
  int          m_acc, m_rej, m_drop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_sv = 1'b0; m_ovf = 1'b0;
      m_acc = 0; m_rej = 0; m_drop = 0;
    end else if (flush) begin
      m_q.delete();
      m_sv = 1'b0;
    end else begin
      m_pop = (m_q.size() != 0) && out_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_sv) begin
        if (m_q.size() < 16) m_q.push_back(m_ss);
        else begin m_ovf = 1'b1; m_drop++; end
      end
      m_sv = valid_in && cmp_value && (rect_idx_in != 8'd0);
      m_ss = exp_in;
      if (m_sv) m_acc++;
      else if (valid_in) m_rej++;
    end
  end

  // Per-cycle comparison of every output against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", 36'(out_valid), 36'(m_q.size() != 0));
      chk("cyc_level", 36'(level), 36'(m_q.size()));
      chk("cyc_out_sample", 36'(out_sample), 36'((m_q.size() != 0) ? m_q[0] : 18'd0));
      chk("cyc_overflow", 36'(overflow), 36'(m_ovf));
      chk("cyc_accept_cnt", 36'(accept_cnt), STATS ? 36'(m_acc) : 36'd0);
      chk("cyc_reject_cnt", 36'(reject_cnt), STATS ? 36'(m_rej) : 36'd0);
      chk("cyc_drop_cnt", 36'(drop_cnt), STATS ? 36'(m_drop) : 36'd0);
    end
  end

  task automatic drive(input logic v, input logic [7:0] idx, input logic [35:0] m,
                       input logic c, input logic [17:0] e);
    @(posedge clk); #1;
    valid_in = v; rect_idx_in = idx; mult_value = m; cmp_value = c; exp_in = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 36'd0, 1'b0, 18'd0);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  idx;
    logic [35:0] m;
    logic        c;
    logic [17:0] e;
  } vec_t;

  vec_t tbl[12];
  int   saved_acc;

  initial begin
    tbl[0]  = '{1'b1, 8'd5,  36'h018000000, 1'b1, 18'h06000};  // +1.5
    tbl[1]  = '{1'b1, 8'd5,  36'h018000000, 1'b0, 18'h00000};  // outside wedge
    tbl[2]  = '{1'b1, 8'd0,  36'h018000000, 1'b1, 18'h00000};  // tail region
    tbl[3]  = '{1'b1, 8'd3,  36'h0A0000000, 1'b1, 18'h1FFFF};  // +10 clamps
    tbl[4]  = '{1'b1, 8'd7,  36'hF60000000, 1'b1, 18'h20000};  // -10 clamps
    tbl[5]  = '{1'b1, 8'd9,  36'hFE8000000, 1'b1, 18'h3A000};  // -1.5
    tbl[6]  = '{1'b0, 8'd5,  36'h018000000, 1'b1, 18'h00000};  // not valid
    tbl[7]  = '{1'b1, 8'd1,  36'h07FFFFFFF, 1'b1, 18'h1FFFF};  // max in range
    tbl[8]  = '{1'b1, 8'd2,  36'h080000000, 1'b1, 18'h1FFFF};  // just above
    tbl[9]  = '{1'b1, 8'd4,  36'hF80000000, 1'b1, 18'h20000};  // min in range
    tbl[10] = '{1'b1, 8'd6,  36'hF7FFFFFFF, 1'b1, 18'h20000};  // just below
    tbl[11] = '{1'b1, 8'd255, 36'hFFFFFFFFF, 1'b1, 18'h3FFFF}; // floor of -eps

    rst = 1'b1; valid_in = 1'b0; rect_idx_in = '0; mult_value = '0;
    cmp_value = 1'b0; flush = 1'b0; out_ready = 1'b1; exp_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset then idle
    idle(10);
    @(negedge clk);
    chk("idle_out_valid", 36'(out_valid), 36'd0);
    chk("idle_level", 36'(level), 36'd0);
    chk("idle_out_sample", 36'(out_sample), 36'd0);
    chk("idle_overflow", 36'(overflow), 36'd0);

    // Two-edge latency of a single accepted bundle
    drive(1'b1, 8'd5, 36'h018000000, 1'b1, 18'h06000);
    idle(1);
    @(negedge clk);
    chk("lat_edge1_valid", 36'(out_valid), 36'd0);
    @(negedge clk);
    chk("lat_edge2_valid", 36'(out_valid), 36'd1);
    chk("lat_edge2_sample", 36'(out_sample), 36'h06000);
    @(negedge clk);
    chk("lat_drained_level", 36'(level), 36'd0);

    // Conversion / accept table
    for (int i = 0; i < 12; i++) drive(tbl[i].v, tbl[i].idx, tbl[i].m, tbl[i].c, tbl[i].e);
    idle(4);
    @(negedge clk);
    chk("tbl_level", 36'(level), 36'd0);
    chk("tbl_reject_cnt", 36'(reject_cnt), STATS ? 36'd2 : 36'd0);

    // Overflow: 20 accepts into a stalled 16-deep FIFO
    out_ready = 1'b0;
    for (int k = 1; k <= 20; k++) drive(1'b1, 8'd8, 36'(k) << 14, 1'b1, 18'(k));
    idle(2);
    @(negedge clk);
    chk("ovf_level", 36'(level), 36'd16);
    chk("ovf_flag", 36'(overflow), 36'd1);
    chk("ovf_drop_cnt", 36'(drop_cnt), STATS ? 36'd4 : 36'd0);
    out_ready = 1'b1;
    idle(18);
    @(negedge clk);
    chk("ovf_drained_valid", 36'(out_valid), 36'd0);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    for (int k = 32; k < 48; k++) drive(1'b1, 8'd10, 36'(k) << 14, 1'b1, 18'(k));
    idle(2);
    @(negedge clk);
    chk("full_level", 36'(level), 36'd16);
    drive(1'b1, 8'd11, 36'(48) << 14, 1'b1, 18'd48);
    for (int k = 49; k < 56; k++) begin
      drive(1'b1, 8'd11, 36'(k) << 14, 1'b1, 18'(k));
      out_ready = 1'b1;
    end
    idle(1);
    idle(1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pp_level", 36'(level), 36'd16);
    chk("pp_drop_cnt", 36'(drop_cnt), STATS ? 36'd4 : 36'd0);
    out_ready = 1'b1;
    idle(18);
    @(negedge clk);
    chk("pp_drained_valid", 36'(out_valid), 36'd0);

    // Flush with an accept presented in the same cycle
    out_ready = 1'b0;
    for (int k = 100; k < 103; k++) drive(1'b1, 8'd12, 36'(k) << 14, 1'b1, 18'(k));
    idle(2);
    @(negedge clk);
    chk("pre_flush_level", 36'(level), 36'd3);
    saved_acc = m_acc;
    drive(1'b1, 8'd12, 36'(120) << 14, 1'b1, 18'd120);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(2);
    @(negedge clk);
    chk("flush_level", 36'(level), 36'd0);
    chk("flush_out_valid", 36'(out_valid), 36'd0);
    chk("flush_accept_cnt", 36'(accept_cnt), STATS ? 36'(saved_acc) : 36'd0);

    // Asynchronous reset while samples are queued and one is in flight
    for (int k = 200; k < 203; k++) drive(1'b1, 8'd13, 36'(k) << 14, 1'b1, 18'(k));
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 36'(out_valid), 36'd0);
    chk("rst_level", 36'(level), 36'd0);
    chk("rst_out_sample", 36'(out_sample), 36'd0);
    chk("rst_overflow", 36'(overflow), 36'd0);
    chk("rst_accept_cnt", 36'(accept_cnt), 36'd0);
    chk("rst_reject_cnt", 36'(reject_cnt), 36'd0);
    chk("rst_drop_cnt", 36'(drop_cnt), 36'd0);
    valid_in = 1'b0; cmp_value = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    idle(4);
    @(negedge clk);
    chk("post_rst_level", 36'(level), 36'd0);
    chk("post_rst_valid", 36'(out_valid), 36'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
